uart_tx_param: RTL and testbench

//  Parametrised UART transmitter: serialises one DATA_BITS-wide word per frame.

---
 rtl/uart_tx_param.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Parametrised UART transmitter. Frame: start bit, DATA_BITS data bits LSB
//   first, optional parity bit, then STOP_BITS stop bits. Includes its own baud
//   counter and bit index, and a ready/valid-style accept handshake.
//
//   Build option: define UART_TX_PARITY_EN to add the PARITY state and the
//   i_Parity_Odd port. Without it, DATA goes straight to STOP.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>=2)
//   DATA_BITS     data bits per frame (5..9)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   i_Clock       system clock, rising edge
//   i_Rst_n       synchronous reset, active low
//   i_Enable      gates frame acceptance only; a running frame always completes
//   i_Tx_DV       data valid; accepted when i_Tx_DV & o_Tx_Ready & i_Enable
//   i_Tx_Data     word to send, sampled on the accept edge
//   i_Parity_Odd  (UART_TX_PARITY_EN) 1 = odd parity, 0 = even, latched on accept
//   o_Tx_Ready    high in IDLE
//   o_Tx_Serial   registered serial line, idle high
//   o_Tx_Active   high from START through STOP
//   o_Tx_Done     one-cycle pulse in CLEANUP
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Enable,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
`ifdef UART_TX_PARITY_EN
  input  logic                 i_Parity_Odd,
`endif
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done
);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end

  localparam int CW = $clog2(2*CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS-1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY  = 3'd3;
`endif
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_CLEANUP = 3'd5;

  logic [2:0]           state, state_nxt;
  logic [CW-1:0]        clk_cnt, cnt_nxt;
  logic [IW-1:0]        bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 ser_q, ser_nxt;
`ifdef UART_TX_PARITY_EN
  logic                 odd_q, odd_nxt;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt + 1'b1;
    idx_nxt   = bit_idx;
    data_nxt  = data_q;
`ifdef UART_TX_PARITY_EN
    odd_nxt   = odd_q;
`endif
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (i_Tx_DV && i_Enable) begin
          data_nxt  = i_Tx_Data;
`ifdef UART_TX_PARITY_EN
          odd_nxt   = i_Parity_Odd;
`endif
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (clk_cnt == BIT_END) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt == BIT_END) begin
          cnt_nxt = '0;
          if (bit_idx < IDX_LAST) begin
            idx_nxt = bit_idx + 1'b1;
          end else begin
            idx_nxt   = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = ST_PARITY;
`else
            state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt == BIT_END) begin
          cnt_nxt   = '0;
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Both stop bits share one count window
        if (clk_cnt == STOP_END) begin
          cnt_nxt   = '0;
          state_nxt = ST_CLEANUP;
        end
      end
      ST_CLEANUP: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        idx_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase

    // Line level is decoded from the next state so the registered output
    // lines up with the state register (start bit appears with START).
    ser_nxt = 1'b1;
    case (state_nxt)
      ST_START:  ser_nxt = 1'b0;
      ST_DATA:   ser_nxt = data_nxt[idx_nxt];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: ser_nxt = (^data_nxt) ^ odd_nxt;
`endif
      default:   ser_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      odd_q   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      clk_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      data_q  <= data_nxt;
      ser_q   <= ser_nxt;
`ifdef UART_TX_PARITY_EN
      odd_q   <= odd_nxt;
`endif
    end
  end

  assign o_Tx_Serial = ser_q;
  assign o_Tx_Ready  = (state == ST_IDLE);
  assign o_Tx_Done   = (state == ST_CLEANUP);
`ifdef UART_TX_PARITY_EN
  assign o_Tx_Active = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_PARITY) || (state == ST_STOP);
`else
  assign o_Tx_Active = (state == ST_START) || (state == ST_DATA) ||
                       (state == ST_STOP);
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: instance A (8 data, 1 stop) and instance B
// (7 data, 2 stop), both at CLKS_PER_BIT=4. Expected frames are queued when a
// word is driven and checked cycle by cycle by a per-instance line monitor.
module tb_uart_tx_param;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en;
  logic       dv_a, dv_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
`ifdef UART_TX_PARITY_EN
  logic       odd_a, odd_b;
`endif
  logic rdy_a, ser_a, act_a, done_a;
  logic rdy_b, ser_b, act_b, done_b;

  int errors = 0;
  int checks = 0;
  bit mon_en_a = 1'b1;

  typedef struct { logic [8:0] data; logic odd; logic par; } vec_t;
  typedef struct { logic [8:0] data; logic par; } sb_t;
  sb_t q_a[$];
  sb_t q_b[$];

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) u_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Tx_DV(dv_a),
    .i_Tx_Data(data_a),
`ifdef UART_TX_PARITY_EN
    .i_Parity_Odd(odd_a),
`endif
    .o_Tx_Ready(rdy_a), .o_Tx_Serial(ser_a), .o_Tx_Active(act_a), .o_Tx_Done(done_a)
  );

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(2)) u_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Tx_DV(dv_b),
    .i_Tx_Data(data_b),
`ifdef UART_TX_PARITY_EN
    .i_Parity_Odd(odd_b),
`endif
    .o_Tx_Ready(rdy_b), .o_Tx_Serial(ser_b), .o_Tx_Active(act_b), .o_Tx_Done(done_b)
  );

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic g_ser(input int w);  return (w == 0) ? ser_a  : ser_b;  endfunction
  function automatic logic g_rdy(input int w);  return (w == 0) ? rdy_a  : rdy_b;  endfunction
  function automatic logic g_act(input int w);  return (w == 0) ? act_a  : act_b;  endfunction
  function automatic logic g_done(input int w); return (w == 0) ? done_a : done_b; endfunction

  // Line monitor: on a falling edge, pops the expected word and checks every
  // cycle of every bit, then the CLEANUP cycle and the following IDLE cycle.
  task automatic mon(input int w);
    logic prev = 1'b1;
    logic s;
    logic exp_bits[16];
    sb_t  it;
    int   n, db, sb, bad;
    bit   ok;
    db = (w == 0) ? 8 : 7;
    sb = (w == 0) ? 1 : 2;
    forever begin
      @(negedge clk);
      s = g_ser(w);
      if (rst_n && (w != 0 || mon_en_a) && prev && !s) begin
        if ((w == 0 && q_a.size() == 0) || (w != 0 && q_b.size() == 0)) begin
          chk(1'b0, $sformatf("unexpected_start_%0d", w), 0, 1);
          it.data = '0; it.par = 1'b0;
        end else if (w == 0) it = q_a.pop_front();
        else                 it = q_b.pop_front();
        n = 0;
        exp_bits[n++] = 1'b0;
        for (int i = 0; i < db; i++) exp_bits[n++] = it.data[i];
        if (P == 1) exp_bits[n++] = it.par;
        for (int i = 0; i < sb; i++) exp_bits[n++] = 1'b1;
        ok = 1'b1; bad = 0;
        for (int t = 0; t < n*CPB; t++) begin
          if (t > 0) @(negedge clk);
          if (g_ser(w) !== exp_bits[t/CPB] || !g_act(w) || g_done(w) || g_rdy(w)) begin
            ok = 1'b0;
            bad = {g_rdy(w), g_done(w), g_act(w), g_ser(w)};
          end
          if (t % CPB == CPB-1) begin
            chk(ok, $sformatf("frame%0d_data%0h_bit%0d(rdy,done,act,ser)", w, it.data, t/CPB),
                bad, {3'b001, exp_bits[t/CPB]});
            ok = 1'b1;
          end
        end
        @(negedge clk);
        chk(g_done(w) && g_ser(w) && !g_act(w), $sformatf("cleanup%0d(done,ser,act)", w),
            {g_done(w), g_ser(w), g_act(w)}, 3'b110);
        @(negedge clk);
        chk(!g_done(w) && g_rdy(w), $sformatf("ready_after_done%0d(done,rdy)", w),
            {g_done(w), g_rdy(w)}, 2'b01);
        s = g_ser(w);
      end
      prev = s;
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input int w);
    int k = 0;
    while (!g_rdy(w) && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) chk(1'b0, $sformatf("ready_timeout%0d", w), 0, 1);
  endtask

  // Drives one word and returns at the negedge after it was accepted.
  task automatic send(input int w, input vec_t v);
    sb_t it;
    int  k = 0;
    wait_ready(w);
    it.data = v.data; it.par = v.par;
    if (w == 0) begin
      q_a.push_back(it); dv_a = 1'b1; data_a = v.data[7:0];
`ifdef UART_TX_PARITY_EN
      odd_a = v.odd;
`endif
    end else begin
      q_b.push_back(it); dv_b = 1'b1; data_b = v.data[6:0];
`ifdef UART_TX_PARITY_EN
      odd_b = v.odd;
`endif
    end
    do begin @(negedge clk); k++; end while (g_rdy(w) && k < 300);
    if (k >= 300) chk(1'b0, $sformatf("accept_timeout%0d", w), 1, 0);
    if (w == 0) dv_a = 1'b0; else dv_b = 1'b0;
  endtask

  vec_t tab_a[7];
  vec_t tab_b[2];
  vec_t v;
  int   k, hi;
  bit   ok;
  sb_t  it;

  initial begin
    // {data, odd, expected parity bit}
    tab_a[0] = '{9'h0A5, 1'b0, 1'b0};
    tab_a[1] = '{9'h007, 1'b0, 1'b1};
    tab_a[2] = '{9'h007, 1'b1, 1'b0};
    tab_a[3] = '{9'h000, 1'b0, 1'b0};
    tab_a[4] = '{9'h0FF, 1'b1, 1'b1};
    tab_a[5] = '{9'h03C, 1'b0, 1'b0};
    tab_a[6] = '{9'h080, 1'b0, 1'b1};
    tab_b[0] = '{9'h07F, 1'b0, 1'b1};
    tab_b[1] = '{9'h015, 1'b1, 1'b0};

    rst_n = 1'b0; en = 1'b1; dv_a = 1'b0; dv_b = 1'b0; data_a = '0; data_b = '0;
`ifdef UART_TX_PARITY_EN
    odd_a = 1'b0; odd_b = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk(ser_a && rdy_a && !act_a && !done_a, "reset_a(ser,rdy,act,done)",
        {ser_a, rdy_a, act_a, done_a}, 4'b1100);
    chk(ser_b && rdy_b && !act_b && !done_b, "reset_b(ser,rdy,act,done)",
        {ser_b, rdy_b, act_b, done_b}, 4'b1100);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) send(0, tab_a[i]);
    for (int i = 0; i < 2; i++) send(1, tab_b[i]);
    wait_ready(0);
    wait_ready(1);
    @(negedge clk);

    // Enable gating, then start latency, then enable dropped mid-frame
    en = 1'b0;
    it.data = 9'h05A; it.par = 1'b0;
    q_a.push_back(it);
    dv_a = 1'b1; data_a = 8'h5A;
`ifdef UART_TX_PARITY_EN
    odd_a = 1'b0;
`endif
    ok = 1'b1;
    repeat (10) begin @(negedge clk); if (!ser_a || !rdy_a) ok = 1'b0; end
    chk(ok, "enable_gate(ser,rdy)", {ser_a, rdy_a}, 2'b11);
    en = 1'b1;
    @(negedge clk);
    chk(ser_a == 1'b0 && !rdy_a, "start_latency(ser,rdy)", {ser_a, rdy_a}, 2'b00);
    dv_a = 1'b0;
    repeat (8) @(negedge clk);
    en = 1'b0;
    wait_ready(0);
    en = 1'b1;
    @(negedge clk);

    // Reset during data bit 3: line high next edge, no Done afterwards
    mon_en_a = 1'b0;
    dv_a = 1'b1; data_a = 8'h00;
    @(negedge clk);
    dv_a = 1'b0;
    repeat (17) @(negedge clk);
    chk(ser_a == 1'b0 && act_a, "pre_reset(ser,act)", {ser_a, act_a}, 2'b01);
    rst_n = 1'b0;
    @(negedge clk);
    chk(ser_a && rdy_a && !act_a && !done_a, "mid_reset(ser,rdy,act,done)",
        {ser_a, rdy_a, act_a, done_a}, 4'b1100);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (50) begin @(negedge clk); if (done_a || !ser_a) ok = 1'b0; end
    chk(ok, "no_done_after_abort(done,ser)", {done_a, ser_a}, 2'b01);
    mon_en_a = 1'b1;
    @(negedge clk);

    // DV held across two frames: gap = CLEANUP + one IDLE cycle
    it.data = 9'h03C; it.par = 1'b0; q_a.push_back(it);
    it.data = 9'h0C3; it.par = 1'b0; q_a.push_back(it);
    dv_a = 1'b1; data_a = 8'h3C;
    k = 0;
    do begin @(negedge clk); k++; end while (rdy_a && k < 50);
    data_a = 8'hC3;
    k = 0;
    while (!done_a && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk(1'b0, "done_timeout", 0, 1);
    hi = 1;
    k = 0;
    do begin @(negedge clk); k++; if (ser_a) hi++; end while (ser_a && k < 10);
    chk(hi == 2, "b2b_gap_cycles", hi, 2);
    dv_a = 1'b0;
    wait_ready(0);
    @(negedge clk);
    @(negedge clk);

    chk(q_a.size() == 0, "queue_a_empty", q_a.size(), 0);
    chk(q_b.size() == 0, "queue_b_empty", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
